// File: rtl/mcu_sys_pkg.sv
// mcu_sys_pkg: register map, reply constant and parser states for the MCU system slice
package mcu_sys_pkg;
  localparam logic [6:0] ADDR_GPIO_OUT = 7'h00;
  localparam logic [6:0] ADDR_GPIO_DIR = 7'h01;
  localparam logic [6:0] ADDR_GPIO_IN = 7'h02;
  localparam logic [6:0] ADDR_ID = 7'h03;
  localparam logic [6:0] ADDR_SCRATCH = 7'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [15:0] DEFAULT_ID = 16'hC3A1;
  typedef enum logic [1:0] {IDLE, GET_HI, GET_LO, RESP} parser_t;
endpackage

// File: rtl/mcu_uart.sv
// mcu_uart: 8N1 receiver with framing-error strobe and transmitter with start/busy handshake
module mcu_uart #(
  parameter int CLK_DIV = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       txd
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  logic rx_act, rxd_d, tx_act;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_bit, tx_bit;
  logic [8:0] tx_sh;
  always_ff @(posedge clk)
    if (rst) begin
      rx_act <= 1'b0;
      rxd_d <= 1'b1;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
    end else begin
      rxd_d <= rxd;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
      if (!rx_act) begin
        if (rxd_d && !rxd) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF_M1;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
      else begin
        rx_cnt <= DIV_M1;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0 && rxd) rx_act <= 1'b0;
        else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          rx_valid <= rxd;
          rx_err <= !rxd;
        end else if (rx_bit != 4'd0) rx_data <= {rxd, rx_data[7:1]};
      end
    end
  // Busy drops in the last stop-bit cycle so a waiting byte follows with no idle gap.
  assign tx_busy = tx_act && !(tx_bit == 4'd9 && tx_cnt == DIV_M1);
  always_ff @(posedge clk)
    if (rst) begin
      tx_act <= 1'b0;
      txd <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else if (tx_start && !tx_busy) begin
      tx_act <= 1'b1;
      tx_sh <= {1'b1, tx_data};
      txd <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_act) begin
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= '0;
        tx_bit <= tx_bit + 1'b1;
        if (tx_bit == 4'd9) begin
          tx_act <= 1'b0;
          txd <= 1'b1;
        end else begin
          txd <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
      end else tx_cnt <= tx_cnt + 1'b1;
    end
endmodule

// File: rtl/mcu_sys_top.sv
// mcu_sys_top: UART-controlled register bridge driving a 16-bit GPIO port, plus JTAG bypass stub
module mcu_sys_top
  import mcu_sys_pkg::*;
#(
  parameter int CLK_DIV = 347,
  parameter logic [15:0] ID_VALUE = DEFAULT_ID
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  output logic        TXD,
  inout  wire  [15:0] GPIOA,
  input  logic        TCK,
  input  logic        TMS,
  input  logic        TDI,
  input  logic        TRST,
  output logic        TDO
);
  logic [1:0] rxd_q, tck_q, tms_q, tdi_q, trst_q;
  logic [15:0] gpio_m, gpio_in, gpio_out, gpio_dir, scratch, rd_data;
  logic tck_d, bypass, unused_tms;
  logic [7:0] rx_data, tx_data, data_hi, lo_byte;
  logic rx_valid, rx_err, tx_start, tx_busy, more;
  logic [6:0] addr, cmd_addr;
  parser_t state;
  always_ff @(posedge CLK)
    if (RST) begin
      rxd_q <= 2'b11;
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      trst_q <= '0;
      tck_d <= 1'b0;
      gpio_m <= '0;
      gpio_in <= '0;
    end else begin
      rxd_q <= {rxd_q[0], RXD};
      tck_q <= {tck_q[0], TCK};
      tms_q <= {tms_q[0], TMS};
      tdi_q <= {tdi_q[0], TDI};
      trst_q <= {trst_q[0], TRST};
      tck_d <= tck_q[1];
      gpio_m <= GPIOA;
      gpio_in <= gpio_m;
    end
  assign unused_tms = tms_q[1];
  always_ff @(posedge CLK)
    if (RST || !trst_q[1]) begin
      bypass <= 1'b0;
      TDO <= 1'b0;
    end else begin
      if (tck_q[1] && !tck_d) bypass <= tdi_q[1];
      if (!tck_q[1] && tck_d) TDO <= bypass;
    end
  for (genvar i = 0; i < 16; i++) begin : g_pad
    assign GPIOA[i] = gpio_dir[i] ? gpio_out[i] : 1'bz;
  end
  mcu_uart #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk(CLK), .rst(RST), .rxd(rxd_q[1]), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .txd(TXD)
  );
  assign cmd_addr = rx_data[6:0];
  always_comb
    rd_data = cmd_addr == ADDR_GPIO_OUT ? gpio_out
            : cmd_addr == ADDR_GPIO_DIR ? gpio_dir
            : cmd_addr == ADDR_GPIO_IN ? gpio_in
            : cmd_addr == ADDR_ID ? ID_VALUE
            : cmd_addr == ADDR_SCRATCH ? scratch : 16'h0000;
  // tx_start is a held request: it drops only once the UART has taken the last reply byte.
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      tx_start <= 1'b0;
      more <= 1'b0;
      tx_data <= '0;
      lo_byte <= '0;
      data_hi <= '0;
      addr <= '0;
      gpio_out <= '0;
      gpio_dir <= '0;
      scratch <= '0;
    end else
      case (state)
        IDLE: if (rx_valid) begin
          addr <= cmd_addr;
          state <= rx_data[7] ? GET_HI : RESP;
          if (!rx_data[7]) begin
            tx_data <= rd_data[15:8];
            lo_byte <= rd_data[7:0];
            tx_start <= 1'b1;
            more <= 1'b1;
          end
        end
        GET_HI: if (rx_err) state <= IDLE;
          else if (rx_valid) begin
            data_hi <= rx_data;
            state <= GET_LO;
          end
        GET_LO: if (rx_err) state <= IDLE;
          else if (rx_valid) begin
            if (addr == ADDR_GPIO_OUT) gpio_out <= {data_hi, rx_data};
            if (addr == ADDR_GPIO_DIR) gpio_dir <= {data_hi, rx_data};
            if (addr == ADDR_SCRATCH) scratch <= {data_hi, rx_data};
            tx_data <= ACK;
            tx_start <= 1'b1;
            more <= 1'b0;
            state <= RESP;
          end
        RESP: if (tx_start && !tx_busy) begin
            tx_data <= lo_byte;
            more <= 1'b0;
            tx_start <= more;
          end else if (!tx_start && !tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mcu_sys_top.sv
// tb_mcu_sys_top: UART-driven register bridge, GPIO pad and JTAG stub checks against a register-map model
module tb_mcu_sys_top;
  localparam int DIV = 20;
  logic CLK = 1'b0, RST = 1'b1, RXD = 1'b1, TCK = 1'b0, TMS = 1'b0, TDI = 1'b0, TRST = 1'b1;
  logic TXD, TDO;
  wire [15:0] GPIOA;
  logic [15:0] tb_drv = '0, tb_oe = '0;
  logic [15:0] m_out = '0, m_dir = '0, m_scr = '0;
  int errors = 0, checks = 0;
  int unsigned cyc = 0;
  for (genvar i = 0; i < 16; i++) begin : g_drv
    assign GPIOA[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
  end
  mcu_sys_top #(.CLK_DIV(DIV), .ID_VALUE(16'hC3A1)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .TXD(TXD), .GPIOA(GPIOA),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TRST(TRST), .TDO(TDO)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      7'd0: return m_out;
      7'd1: return m_dir;
      7'd2: return (m_out & m_dir) | (tb_drv & ~m_dir);
      7'd3: return 16'hC3A1;
      7'd4: return m_scr;
      default: return 16'h0000;
    endcase
  endfunction
  task automatic m_write(input logic [6:0] a, input logic [15:0] d);
    if (a == 7'd0) m_out = d;
    else if (a == 7'd1) m_dir = d;
    else if (a == 7'd4) m_scr = d;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic bad = 1'b0);
    logic [9:0] f;
    f = {~bad, b, 1'b0};
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (DIV) @(negedge CLK);
    end
    RXD = 1'b1;
  endtask
  task automatic recv_byte(output logic [7:0] b, output logic ok, output int unsigned t0, input int limit);
    int n;
    n = 0;
    ok = 1'b0;
    b = '0;
    t0 = 0;
    while (TXD !== 1'b0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (TXD !== 1'b0) return;
    t0 = cyc;
    repeat (DIV / 2) @(negedge CLK);
    if (TXD !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge CLK);
      b[i] = TXD;
    end
    repeat (DIV) @(negedge CLK);
    ok = (TXD === 1'b1);
  endtask
  task automatic do_write(input logic [6:0] a, input logic [15:0] d, output logic [7:0] r, output logic ok);
    int unsigned t;
    fork
      begin
        send_byte({1'b1, a});
        send_byte(d[15:8]);
        send_byte(d[7:0]);
      end
      recv_byte(r, ok, t, 40 * DIV);
    join
    repeat (DIV) @(negedge CLK);
  endtask
  task automatic do_read(input logic [6:0] a, output logic [15:0] d, output logic ok, output int unsigned gap);
    logic [7:0] h, l;
    logic ok1, ok2;
    int unsigned t1, t2;
    fork
      send_byte({1'b0, a});
      begin
        recv_byte(h, ok1, t1, 20 * DIV);
        recv_byte(l, ok2, t2, 20 * DIV);
      end
    join
    d = {h, l};
    ok = ok1 && ok2;
    gap = t2 - t1;
    repeat (DIV) @(negedge CLK);
  endtask
  task automatic test_reset();
    logic [15:0] d;
    logic ok;
    int unsigned gap;
    tb_drv = 16'h5AA5;
    tb_oe = 16'hFFFF;
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (TXD !== 1'b1 || GPIOA !== 16'h5AA5) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: TXD=%b GPIOA=%h, want TXD=1 GPIOA=5aa5 (pads undriven by DUT)", i, TXD, GPIOA);
      end
    end
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (TDO !== 1'b0) begin
      errors++;
      $display("FAIL reset_tdo: got %b want 0", TDO);
    end
    do_read(7'h03, d, ok, gap);
    checks++;
    if (!ok || d !== 16'hC3A1) begin
      errors++;
      $display("FAIL reset_read_id: got %h ok=%b want c3a1", d, ok);
    end
    checks++;
    if (gap !== 10 * DIV) begin
      errors++;
      $display("FAIL reply_back_to_back: byte spacing %0d want %0d", gap, 10 * DIV);
    end
  endtask
  task automatic test_gpio_out();
    logic [7:0] r;
    logic ok;
    tb_oe = 16'h0000;
    do_write(7'h01, 16'hFFFF, r, ok);
    m_write(7'h01, 16'hFFFF);
    checks++;
    if (!ok || r !== 8'h06) begin
      errors++;
      $display("FAIL gpio_dir_ack: got %h ok=%b want 06", r, ok);
    end
    do_write(7'h00, 16'hA55A, r, ok);
    m_write(7'h00, 16'hA55A);
    checks++;
    if (!ok || r !== 8'h06) begin
      errors++;
      $display("FAIL gpio_out_ack: got %h ok=%b want 06", r, ok);
    end
    checks++;
    if (GPIOA !== 16'hA55A) begin
      errors++;
      $display("FAIL gpio_out_pads: got %h want a55a", GPIOA);
    end
  endtask
  task automatic test_gpio_in();
    logic [7:0] r;
    logic [15:0] d;
    logic ok;
    int unsigned gap;
    do_write(7'h01, 16'h00FF, r, ok);
    m_write(7'h01, 16'h00FF);
    tb_drv = 16'h3C00;
    tb_oe = ~m_dir;
    do_write(7'h00, 16'h0012, r, ok);
    m_write(7'h00, 16'h0012);
    checks++;
    if (!ok || r !== 8'h06) begin
      errors++;
      $display("FAIL gpio_in_setup_ack: got %h ok=%b want 06", r, ok);
    end
    do_read(7'h02, d, ok, gap);
    checks++;
    if (!ok || d !== 16'h3C12 || d !== m_read(7'h02)) begin
      errors++;
      $display("FAIL gpio_in_read: got %h ok=%b want 3c12", d, ok);
    end
  endtask
  task automatic test_scratch_unmapped();
    logic [7:0] r;
    logic [15:0] d;
    logic ok;
    int unsigned gap;
    do_write(7'h04, 16'hBEEF, r, ok);
    m_write(7'h04, 16'hBEEF);
    do_read(7'h04, d, ok, gap);
    checks++;
    if (!ok || d !== 16'hBEEF) begin
      errors++;
      $display("FAIL scratch_read: got %h ok=%b want beef", d, ok);
    end
    do_write(7'h7F, 16'h1234, r, ok);
    checks++;
    if (!ok || r !== 8'h06) begin
      errors++;
      $display("FAIL unmapped_write_ack: got %h ok=%b want 06", r, ok);
    end
    do_read(7'h7F, d, ok, gap);
    checks++;
    if (!ok || d !== 16'h0000) begin
      errors++;
      $display("FAIL unmapped_read: got %h ok=%b want 0000", d, ok);
    end
    do_write(7'h03, 16'h5555, r, ok);
    do_read(7'h03, d, ok, gap);
    checks++;
    if (!ok || d !== 16'hC3A1) begin
      errors++;
      $display("FAIL id_read_only: got %h ok=%b want c3a1", d, ok);
    end
  endtask
  task automatic test_framing();
    logic [7:0] r;
    logic [15:0] d;
    logic ok;
    int unsigned t, gap;
    fork
      send_byte(8'h03, 1'b1);
      recv_byte(r, ok, t, 25 * DIV);
    join
    checks++;
    if (ok !== 1'b0) begin
      errors++;
      $display("FAIL framing_cmd_no_reply: got reply %h want none", r);
    end
    repeat (DIV) @(negedge CLK);
    fork
      begin
        send_byte(8'h84);
        send_byte(8'h11);
        send_byte(8'h22, 1'b1);
      end
      recv_byte(r, ok, t, 45 * DIV);
    join
    checks++;
    if (ok !== 1'b0) begin
      errors++;
      $display("FAIL framing_data_no_reply: got reply %h want none", r);
    end
    repeat (DIV) @(negedge CLK);
    do_read(7'h04, d, ok, gap);
    checks++;
    if (!ok || d !== m_read(7'h04)) begin
      errors++;
      $display("FAIL framing_no_commit: got %h ok=%b want %h", d, ok, m_read(7'h04));
    end
    do_read(7'h03, d, ok, gap);
    checks++;
    if (!ok || d !== 16'hC3A1) begin
      errors++;
      $display("FAIL framing_recover_id: got %h ok=%b want c3a1", d, ok);
    end
  endtask
  task automatic test_reset_mid_reply();
    logic [15:0] d;
    logic ok;
    int unsigned gap;
    int n;
    fork
      send_byte(8'h03);
      begin
        n = 0;
        while (TXD !== 1'b0 && n < 30 * DIV) begin
          @(negedge CLK);
          n++;
        end
        repeat (3 * DIV + DIV / 2) @(negedge CLK);
        checks++;
        if (TXD !== 1'b0) begin
          errors++;
          $display("FAIL mid_reply_bit: TXD=%b want 0 before reset", TXD);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (TXD !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_reply: TXD=%b want 1", TXD);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
      end
    join
    m_out = '0;
    m_dir = '0;
    m_scr = '0;
    tb_oe = ~m_dir;
    repeat (2 * DIV) @(negedge CLK);
    do_read(7'h01, d, ok, gap);
    checks++;
    if (!ok || d !== 16'h0000) begin
      errors++;
      $display("FAIL reset_clears_dir: got %h ok=%b want 0000", d, ok);
    end
  endtask
  task automatic test_jtag();
    logic [3:0] pat;
    logic prev;
    pat = 4'b1101;
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      TDI = pat[k];
      TMS = 1'($urandom);
      repeat (4) @(negedge CLK);
      TCK = 1'b1;
      repeat (8) @(negedge CLK);
      checks++;
      if (TDO !== prev) begin
        errors++;
        $display("FAIL jtag_hold_%0d: TDO=%b want %b before falling edge", k, TDO, prev);
      end
      TCK = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if (TDO !== prev) begin
        errors++;
        $display("FAIL jtag_early_%0d: TDO=%b want %b two cycles after fall", k, TDO, prev);
      end
      @(negedge CLK);
      checks++;
      if (TDO !== pat[k]) begin
        errors++;
        $display("FAIL jtag_tdo_%0d: TDO=%b want %b", k, TDO, pat[k]);
      end
      prev = pat[k];
      @(negedge CLK);
    end
    TRST = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (TDO !== 1'b0) begin
      errors++;
      $display("FAIL jtag_trst: TDO=%b want 0", TDO);
    end
    TRST = 1'b1;
    repeat (4) @(negedge CLK);
  endtask
  task automatic test_random();
    logic [7:0] r;
    logic [15:0] d, exp;
    logic [6:0] a;
    logic ok;
    int unsigned gap;
    for (int n = 0; n < 10; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
      tb_drv = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        if (a == 7'd1) tb_oe = ~(m_dir | d);
        do_write(a, d, r, ok);
        m_write(a, d);
        tb_oe = ~m_dir;
        @(negedge CLK);
        checks++;
        if (!ok || r !== 8'h06) begin
          errors++;
          $display("FAIL rand_write_ack[%0d] addr %h: got %h ok=%b want 06", n, a, r, ok);
        end
        checks++;
        if (GPIOA !== ((m_out & m_dir) | (tb_drv & ~m_dir))) begin
          errors++;
          $display("FAIL rand_pads[%0d]: got %h want %h", n, GPIOA, (m_out & m_dir) | (tb_drv & ~m_dir));
        end
      end else begin
        exp = m_read(a);
        do_read(a, d, ok, gap);
        checks++;
        if (!ok || d !== exp || gap !== 10 * DIV) begin
          errors++;
          $display("FAIL rand_read[%0d] addr %h: got %h ok=%b gap=%0d want %h gap=%0d", n, a, d, ok, gap, exp, 10 * DIV);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_gpio_out();
    test_gpio_in();
    test_scratch_unmapped();
    test_framing();
    test_jtag();
    test_random();
    test_reset_mid_reply();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcu_sys_top.md
# mcu_sys_top

- Compact MCU system top: a UART-controlled register bridge driving a 16-bit GPIO port, plus a JTAG bypass stub on the debug pins.
- A host issues read/write commands over the UART pins. The block executes them on a small register file and replies over the same UART.
- It sits at chip level as the sole module between the pads and the system-level simulation monitor.

## Interface
Parameters:
- CLK_DIV, 347: CLK cycles per UART bit (40 MHz / 115200).
- ID_VALUE, 16'hC3A1: value of the read-only ID register.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- RXD  in  1  UART receive, 8N1, idle high.
- TXD  out  1  UART transmit, 8N1, idle high.
- GPIOA  inout  16  GPIO pads; bit i is driven only when DIR[i]=1, otherwise high-Z.
- TCK, TMS, TDI  in  1 each  JTAG inputs, sampled in the CLK domain.
- TRST  in  1  JTAG reset, active-low, synchronized.
- TDO  out  1  JTAG data out.

## Operation
- **Reset values:** TXD=1, TDO=0, GPIO_OUT=0, GPIO_DIR=0 (all pads high-Z), SCRATCH=0, parser in IDLE, UART RX/TX idle.
- **Input synchronization:** RXD, TCK, TMS, TDI, TRST and GPIOA inputs each pass through two flops before use.
- **Register map** (7-bit address, 16-bit data):
  - 0x00 GPIO_OUT: rw.
  - 0x01 GPIO_DIR: rw; 1 = output.
  - 0x02 GPIO_IN: ro; synchronized pad values. An output bit reads back its own driven value.
  - 0x03 ID: ro; reads ID_VALUE.
  - 0x04 SCRATCH: rw.
  - Other addresses read 0x0000. Writes to them, and to read-only registers, are ignored.
- **Command byte:** bit7 = R/W (1 = write), bits[6:0] = address.
- **Write frame:** command byte, data_hi, data_lo. The write commits on the cycle data_lo completes. Reply is one byte, 0x06 (ACK).
- **Read frame:** command byte only. Data is captured on the cycle the command byte completes. Reply is data_hi then data_lo.
- **Parser FSM:**
  - States: IDLE, GET_HI, GET_LO, RESP.
  - IDLE→GET_HI on a write command; IDLE→RESP on a read command.
  - GET_HI→GET_LO and GET_LO→RESP on each received byte.
  - RESP→IDLE after the last reply byte's stop bit.
  - Bytes received during RESP are discarded.
- **Framing error:** a byte whose stop bit samples 0 is dropped and forces the parser to IDLE with no reply.
- **JTAG stub:**
  - On a synchronized TCK rising edge, bypass flop ← TDI.
  - On a synchronized TCK falling edge, TDO ← bypass flop.
  - Synchronized TRST=0 clears both flops. TMS is ignored.

## Timing
- **UART RX:**
  - A start bit is a synchronized falling edge while the receiver is idle.
  - The start bit is re-checked at CLK_DIV/2 cycles; if RXD is high, it is a glitch and the receiver returns to idle.
  - Data bits are sampled every CLK_DIV cycles after that, LSB first, followed by the stop bit.
  - A byte is valid one cycle after the stop-bit sample.
- **UART TX:** each bit is held exactly CLK_DIV cycles, LSB first, with one stop bit. Back-to-back reply bytes have no idle gap.
- **Reply latency:** the first reply start bit begins 2 CLK cycles after the final request byte is valid.
- **GPIO:**
  - A write to GPIO_OUT or GPIO_DIR appears on the pads 1 cycle after commit.
  - GPIO_IN reflects the pads 2 cycles later.
- **JTAG:** TDO changes 3 CLK cycles after the TCK falling edge (2 sync cycles + 1 edge-detect cycle). This requires TCK ≤ CLK/8.
- **Reset mid-frame:** RST asserted mid-frame aborts both RX and TX. TXD returns to 1 on the next cycle.

## Structure
- Package mcu_sys_pkg holds:
  - register addresses,
  - the ACK constant (8'h06),
  - the parser state enum,
  - the default ID value.
- One sub-module, mcu_uart: RX plus TX, parameterized by CLK_DIV, with a byte-valid strobe out and a tx_start/tx_busy handshake.
- Instantiate mcu_uart once. The parser, register file, GPIO tristates and JTAG stub live in mcu_sys_top.

## Test plan
- **Reset:** hold RST for 10 cycles, then read 0x03 → reply C3 A1. TXD stays high and GPIOA stays Z throughout reset.
- **GPIO out:** write 0x01=FFFF, then write 0x00=A55A → two ACK 0x06 replies, and GPIOA=A55A within 1 cycle of the second commit.
- **GPIO in:** DIR=00FF, OUT=0012, bench drives GPIOA[15:8]=0x3C → read 0x02 returns 3C 12.
- **Scratch and unmapped:** write 0x04=BEEF and read it back → BE EF. Write 0x7F=1234 → ACK, and a read of 0x7F returns 00 00.
- **Error and reset recovery:**
  - A command byte with a bad stop bit gets no reply; a following read of 0x03 still returns C3 A1.
  - RST asserted mid-reply puts TXD=1 next cycle.
- **JTAG:** drive TDI pattern 1,0,1,1 over 4 TCK cycles at CLK/16 → TDO shows the same pattern one TCK cycle later. TRST=0 forces TDO=0.
